mem_or_io: RTL and testbench



---
 rtl/mem_or_io.sv | 37 +++
 tb/tb_mem_or_io.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_or_io.sv
// mem_or_io: steers load/store data between the CPU datapath, data memory and memory-mapped I/O.
module mem_or_io #(
  parameter int DATA_W = 32,
  parameter int IO_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mRead,
  input  logic              mWrite,
  input  logic              ioRead,
  input  logic              ioWrite,
  input  logic [DATA_W-1:0] addr_in,
  output logic [DATA_W-1:0] addr_out,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [IO_W-1:0]   io_rdata,
  output logic [DATA_W-1:0] r_wdata,
  input  logic [DATA_W-1:0] r_rdata,
  output logic [DATA_W-1:0] write_data,
  output logic              LEDCtrl,
  output logic              SwitchCtrl
);
  logic              store;
  logic [DATA_W-1:0] wd_hold_q, wd_hold_d;
  always_comb begin
    store      = mWrite | ioWrite;
    addr_out   = addr_in;
    r_wdata    = mRead ? m_rdata : {{(DATA_W-IO_W){1'b0}}, io_rdata};
    LEDCtrl    = ioWrite;
    SwitchCtrl = ioRead;
    wd_hold_d  = store ? r_rdata : wd_hold_q;
    write_data = store ? r_rdata : wd_hold_q;
  end
  // Last stored value stays on the bus between stores instead of floating.
  always_ff @(posedge clock or posedge reset)
    if (reset) wd_hold_q <= '0;
    else       wd_hold_q <= wd_hold_d;
endmodule

// File: tb/tb_mem_or_io.sv
// tb_mem_or_io: directed and randomized checks of mem_or_io against a behavioural model.
module tb_mem_or_io;
  logic        clock = 0, reset = 0;
  logic        mRead = 0, mWrite = 0, ioRead = 0, ioWrite = 0;
  logic [31:0] addr_in = 0, m_rdata = 0, r_rdata = 0;
  logic [15:0] io_rdata = 0;
  logic [31:0] addr_out, r_wdata, write_data;
  logic        LEDCtrl, SwitchCtrl;
  int          n_checks = 0, n_err = 0;
  logic [31:0] model_hold = 0;

  mem_or_io dut (
    .clock(clock), .reset(reset), .mRead(mRead), .mWrite(mWrite),
    .ioRead(ioRead), .ioWrite(ioWrite), .addr_in(addr_in), .addr_out(addr_out),
    .m_rdata(m_rdata), .io_rdata(io_rdata), .r_wdata(r_wdata), .r_rdata(r_rdata),
    .write_data(write_data), .LEDCtrl(LEDCtrl), .SwitchCtrl(SwitchCtrl)
  );

  always #5 clock = ~clock;

  task automatic strobes(input logic [3:0] s);
    {mRead, mWrite, ioRead, ioWrite} = s;
  endtask

  task automatic cyc();
    @(posedge clock);
    if (reset) model_hold = 0;
    else if (mWrite || ioWrite) model_hold = r_rdata;
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    strobes(4'b0000); r_rdata = 32'hDEADBEEF;
    reset = 1; model_hold = 0; #1;
    n_checks++; if (write_data !== 32'h0) begin n_err++; $display("FAIL reset_wd got=%h exp=%h", write_data, 32'h0); end
    cyc(); reset = 0; #1;
    n_checks++; if (write_data !== 32'h0) begin n_err++; $display("FAIL reset_release_wd got=%h exp=%h", write_data, 32'h0); end
  endtask

  task automatic test_mem_store();
    addr_in = 32'h4; m_rdata = 32'hFFFF0001; io_rdata = 16'hFFFF; r_rdata = 32'h0F0F0F0F;
    strobes(4'b0100); #1;
    n_checks++; if (addr_out !== 32'h4) begin n_err++; $display("FAIL mst_addr got=%h exp=%h", addr_out, 32'h4); end
    n_checks++; if (write_data !== 32'h0F0F0F0F) begin n_err++; $display("FAIL mst_wd got=%h exp=%h", write_data, 32'h0F0F0F0F); end
    n_checks++; if ({LEDCtrl, SwitchCtrl} !== 2'b00) begin n_err++; $display("FAIL mst_ctrl got=%b exp=00", {LEDCtrl, SwitchCtrl}); end
    cyc();
  endtask

  task automatic test_led_store();
    addr_in = 32'hFFFFFC60; strobes(4'b0001); #1;
    n_checks++; if (addr_out !== 32'hFFFFFC60) begin n_err++; $display("FAIL led_addr got=%h exp=%h", addr_out, 32'hFFFFFC60); end
    n_checks++; if (write_data !== 32'h0F0F0F0F) begin n_err++; $display("FAIL led_wd got=%h exp=%h", write_data, 32'h0F0F0F0F); end
    n_checks++; if ({LEDCtrl, SwitchCtrl} !== 2'b10) begin n_err++; $display("FAIL led_ctrl got=%b exp=10", {LEDCtrl, SwitchCtrl}); end
    cyc();
  endtask

  task automatic test_loads();
    addr_in = 32'h4; strobes(4'b1000); #1;
    n_checks++; if (r_wdata !== 32'hFFFF0001) begin n_err++; $display("FAIL mld_rw got=%h exp=%h", r_wdata, 32'hFFFF0001); end
    n_checks++; if ({LEDCtrl, SwitchCtrl} !== 2'b00) begin n_err++; $display("FAIL mld_ctrl got=%b exp=00", {LEDCtrl, SwitchCtrl}); end
    addr_in = 32'hFFFFFC70; strobes(4'b0010); #1;
    n_checks++; if (addr_out !== 32'hFFFFFC70) begin n_err++; $display("FAIL sw_addr got=%h exp=%h", addr_out, 32'hFFFFFC70); end
    n_checks++; if (r_wdata !== 32'h0000FFFF) begin n_err++; $display("FAIL sw_rw got=%h exp=%h", r_wdata, 32'h0000FFFF); end
    n_checks++; if ({LEDCtrl, SwitchCtrl} !== 2'b01) begin n_err++; $display("FAIL sw_ctrl got=%b exp=01", {LEDCtrl, SwitchCtrl}); end
    strobes(4'b1010); #1;
    n_checks++; if (r_wdata !== 32'hFFFF0001) begin n_err++; $display("FAIL prio_rw got=%h exp=%h", r_wdata, 32'hFFFF0001); end
    n_checks++; if (SwitchCtrl !== 1'b1) begin n_err++; $display("FAIL prio_sw got=%b exp=1", SwitchCtrl); end
    cyc();
  endtask

  task automatic test_hold_reset();
    reset = 1; strobes(4'b0000); model_hold = 0; cyc(); reset = 0; #1;
    n_checks++; if (write_data !== 32'h0) begin n_err++; $display("FAIL hold_pre got=%h exp=0", write_data); end
    r_rdata = 32'h12345678; strobes(4'b0100); cyc();
    strobes(4'b0000); r_rdata = 32'hCAFEF00D; #1;
    n_checks++; if (write_data !== 32'h12345678) begin n_err++; $display("FAIL hold_keep got=%h exp=%h", write_data, 32'h12345678); end
    cyc();
    n_checks++; if (write_data !== 32'h12345678) begin n_err++; $display("FAIL hold_keep2 got=%h exp=%h", write_data, 32'h12345678); end
    reset = 1; #1;
    n_checks++; if (write_data !== 32'h0) begin n_err++; $display("FAIL hold_async_rst got=%h exp=0", write_data); end
    r_rdata = 32'hA5A5A5A5; strobes(4'b0101); #1;
    n_checks++; if (write_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL rst_store_wd got=%h exp=%h", write_data, 32'hA5A5A5A5); end
    n_checks++; if (LEDCtrl !== 1'b1) begin n_err++; $display("FAIL dual_led got=%b exp=1", LEDCtrl); end
    cyc(); strobes(4'b0000); #1;
    n_checks++; if (write_data !== 32'h0) begin n_err++; $display("FAIL rst_no_capture got=%h exp=0", write_data); end
    reset = 0; model_hold = 0; cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] e_rw, e_wd;
      addr_in = $urandom; m_rdata = $urandom; r_rdata = $urandom; io_rdata = 16'($urandom);
      strobes(4'($urandom));
      reset = ($urandom_range(0, 15) == 0);
      if (reset) model_hold = 0;
      #1;
      e_rw = mRead ? m_rdata : {16'h0, io_rdata};
      e_wd = (mWrite || ioWrite) ? r_rdata : model_hold;
      n_checks++; if (addr_out !== addr_in) begin n_err++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, addr_out, addr_in); end
      n_checks++; if (r_wdata !== e_rw) begin n_err++; $display("FAIL rnd_rw i=%0d got=%h exp=%h", i, r_wdata, e_rw); end
      n_checks++; if (write_data !== e_wd) begin n_err++; $display("FAIL rnd_wd i=%0d got=%h exp=%h", i, write_data, e_wd); end
      n_checks++; if ({LEDCtrl, SwitchCtrl} !== {ioWrite, ioRead}) begin n_err++; $display("FAIL rnd_ctrl i=%0d got=%b exp=%b", i, {LEDCtrl, SwitchCtrl}, {ioWrite, ioRead}); end
      cyc();
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_mem_store();
    test_led_store();
    test_loads();
    test_hold_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
